// File: rtl/hdu_branch_ctrl_pkg.sv
// Shared hazard-unit definitions: jump-type encodings, predictor reset value,
// branch-control FSM states and the flag-based branch resolution helper.
package hdu_branch_ctrl_pkg;

    typedef enum logic [2:0] {
        JT_NONE   = 3'd0,
        JT_JZ     = 3'd1,
        JT_JN     = 3'd2,
        JT_JC     = 3'd3,
        JT_UNCOND = 3'd4
    } jump_type_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } hdu_state_e;

    localparam logic [1:0] PRED_RESET = 2'b01;

    function automatic logic is_resolvable(input logic [2:0] jtype);
        return (jtype == JT_JZ) || (jtype == JT_JN) ||
               (jtype == JT_JC) || (jtype == JT_UNCOND);
    endfunction

    // zcn = {carry, negative, zero}
    function automatic logic resolve_taken(input logic [2:0] jtype, input logic [2:0] zcn);
        case (jtype)
            JT_JZ:     return zcn[0];
            JT_JN:     return zcn[1];
            JT_JC:     return zcn[2];
            JT_UNCOND: return 1'b1;
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/hdu_branch_ctrl_sat_counter_table.sv
// Table of 2-bit saturating branch predictor counters with one combinational
// read port (counter MSB) and one synchronous update port.
module sat_counter_table
    import hdu_branch_ctrl_pkg::*;
#(
    parameter int unsigned IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_pred,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken
);

    localparam int unsigned DEPTH = 1 << IDX_W;

    logic [1:0] cnt_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                cnt_q[i] <= PRED_RESET;
            end
        end else if (upd_en) begin
            if (upd_taken && (cnt_q[upd_idx] != 2'b11)) begin
                cnt_q[upd_idx] <= cnt_q[upd_idx] + 2'd1;
            end else if (!upd_taken && (cnt_q[upd_idx] != 2'b00)) begin
                cnt_q[upd_idx] <= cnt_q[upd_idx] - 2'd1;
            end
        end
    end

    // Reads the registered table, so a same-cycle update is not visible yet.
    assign rd_pred = cnt_q[rd_idx][1];

endmodule

// File: rtl/hdu_branch_ctrl.sv
// Branch hazard controller: resolves EX-stage branches against the flags,
// trains the predictor, and sequences flush/redirect on a mispredict.
module hdu_branch_ctrl
    import hdu_branch_ctrl_pkg::*;
#(
    parameter int unsigned FLAG_W       = 4,
    parameter int unsigned IDX_W        = 4,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [IDX_W-1:0]  i_if_idx,
    output logic              o_if_pred_taken,
    input  logic              i_ex_valid,
    input  logic [2:0]        i_ex_type,
    input  logic [IDX_W-1:0]  i_ex_idx,
    input  logic              i_ex_pred_taken,
    input  logic [FLAG_W-1:0] i_flags,
    output logic              o_flush,
    output logic              o_redirect,
    output logic              o_redirect_taken,
    output logic              o_busy,
    output logic [CNT_W-1:0]  o_mispredict_cnt
);

    localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

    hdu_state_e state;
    logic [3:0] flush_cnt;
    logic       resolved;
    logic       actual_taken;
    logic       mispredict;
    logic       upd_en;
    logic       unused_flags;

    // Only zero/negative/carry take part in resolution.
    assign unused_flags = ^i_flags;

    assign resolved     = i_ex_valid && (state == ST_IDLE) && is_resolvable(i_ex_type);
    assign actual_taken = resolve_taken(i_ex_type, i_flags[2:0]);
    assign mispredict   = resolved && (actual_taken != i_ex_pred_taken);
    assign upd_en       = resolved && (i_ex_type != JT_UNCOND);

    sat_counter_table #(
        .IDX_W (IDX_W)
    ) u_table (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .rd_idx    (i_if_idx),
        .rd_pred   (o_if_pred_taken),
        .upd_en    (upd_en),
        .upd_idx   (i_ex_idx),
        .upd_taken (actual_taken)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state            <= ST_IDLE;
            flush_cnt        <= '0;
            o_flush          <= 1'b0;
            o_redirect       <= 1'b0;
            o_redirect_taken <= 1'b0;
            o_busy           <= 1'b0;
            o_mispredict_cnt <= '0;
        end else begin
            o_redirect <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (mispredict) begin
                        state            <= ST_FLUSH;
                        flush_cnt        <= '0;
                        o_flush          <= 1'b1;
                        o_busy           <= 1'b1;
                        o_redirect       <= 1'b1;
                        o_redirect_taken <= actual_taken;
                        if (o_mispredict_cnt != '1) begin
                            o_mispredict_cnt <= o_mispredict_cnt + 1'b1;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt == FLUSH_LAST) begin
                        state     <= ST_IDLE;
                        flush_cnt <= '0;
                        o_flush   <= 1'b0;
                        o_busy    <= 1'b0;
                    end else begin
                        flush_cnt <= flush_cnt + 4'd1;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    o_flush <= 1'b0;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hdu_branch_ctrl.sv
// Directed bench for hdu_branch_ctrl: default instance plus a FLUSH_CYCLES=1,
// CNT_W=2 instance, checked against a scoreboarded behavioural model.
module tb_hdu_branch_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] if_idx = '0;
    logic       ex_valid = 1'b0;
    logic [2:0] ex_type = '0;
    logic [3:0] ex_idx = '0;
    logic       ex_pred = 1'b0;
    logic [3:0] flags = '0;

    logic        pred0, fl0, rd0, rt0, bz0;
    logic [15:0] cnt0;
    logic        pred1, fl1, rd1, rt1, bz1;
    logic [1:0]  cnt1;

    always #5 clk = ~clk;

    hdu_branch_ctrl #(
        .FLAG_W(4), .IDX_W(4), .FLUSH_CYCLES(2), .CNT_W(16)
    ) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_if_idx(if_idx), .o_if_pred_taken(pred0),
        .i_ex_valid(ex_valid), .i_ex_type(ex_type), .i_ex_idx(ex_idx),
        .i_ex_pred_taken(ex_pred), .i_flags(flags), .o_flush(fl0),
        .o_redirect(rd0), .o_redirect_taken(rt0), .o_busy(bz0), .o_mispredict_cnt(cnt0)
    );

    hdu_branch_ctrl #(
        .FLAG_W(4), .IDX_W(4), .FLUSH_CYCLES(1), .CNT_W(2)
    ) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_if_idx(if_idx), .o_if_pred_taken(pred1),
        .i_ex_valid(ex_valid), .i_ex_type(ex_type), .i_ex_idx(ex_idx),
        .i_ex_pred_taken(ex_pred), .i_flags(flags), .o_flush(fl1),
        .o_redirect(rd1), .o_redirect_taken(rt1), .o_busy(bz1), .o_mispredict_cnt(cnt1)
    );

    typedef struct {
        logic        fl;
        logic        rd;
        logic        rt;
        logic        bz;
        logic [31:0] cnt;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int          checks = 0;
    int          errors = 0;
    int          m_left [2];
    logic [31:0] m_cnt  [2];
    logic [1:0]  m_tab  [2][16];
    int          fc     [2] = '{2, 1};
    logic [31:0] cmax   [2] = '{32'hFFFF, 32'd3};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_left[k] = 0;
            m_cnt[k]  = '0;
            for (int i = 0; i < 16; i++) m_tab[k][i] = 2'b01;
        end
        q0.delete();
        q1.delete();
    endtask

    function automatic logic act_taken(input logic [2:0] t, input logic [3:0] f);
        case (t)
            3'd1:    return f[0];
            3'd2:    return f[1];
            3'd3:    return f[2];
            3'd4:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic compare(input string who, input exp_t e, input logic fl, input logic rd,
                           input logic rt, input logic bz, input logic [31:0] cnt);
        chk({who, "_flush"}, {31'd0, fl}, {31'd0, e.fl});
        chk({who, "_redirect"}, {31'd0, rd}, {31'd0, e.rd});
        chk({who, "_busy"}, {31'd0, bz}, {31'd0, e.bz});
        chk({who, "_mispredict_cnt"}, cnt, e.cnt);
        if (e.rd) chk({who, "_redirect_taken"}, {31'd0, rt}, {31'd0, e.rt});
    endtask

    task automatic cycle(input logic v, input logic [2:0] t, input logic [3:0] idx,
                         input logic p, input logic [3:0] f, input logic [3:0] ii);
        exp_t e;
        logic a;
        @(negedge clk);
        ex_valid = v; ex_type = t; ex_idx = idx; ex_pred = p; flags = f; if_idx = ii;
        #1;
        chk("pred0", {31'd0, pred0}, {31'd0, m_tab[0][ii][1]});
        chk("pred1", {31'd0, pred1}, {31'd0, m_tab[1][ii][1]});
        a = act_taken(t, f);
        for (int k = 0; k < 2; k++) begin
            e.rd = 1'b0;
            e.rt = 1'b0;
            if (m_left[k] == 0 && v && t >= 3'd1 && t <= 3'd4) begin
                if (t != 3'd4) begin
                    if (a && m_tab[k][idx] != 2'b11) m_tab[k][idx] = m_tab[k][idx] + 2'd1;
                    if (!a && m_tab[k][idx] != 2'b00) m_tab[k][idx] = m_tab[k][idx] - 2'd1;
                end
                if (a != p) begin
                    m_left[k] = fc[k];
                    if (m_cnt[k] != cmax[k]) m_cnt[k] = m_cnt[k] + 1;
                    e.rd = 1'b1;
                    e.rt = a;
                end
            end else if (m_left[k] > 0) begin
                m_left[k] = m_left[k] - 1;
            end
            e.fl  = (m_left[k] > 0);
            e.bz  = e.fl;
            e.cnt = m_cnt[k];
            if (k == 0) q0.push_back(e); else q1.push_back(e);
        end
        @(posedge clk);
        #1;
        compare("dut0", q0.pop_front(), fl0, rd0, rt0, bz0, {16'd0, cnt0});
        compare("dut1", q1.pop_front(), fl1, rd1, rt1, bz1, {30'd0, cnt1});
    endtask

    task automatic idle(input int n, input logic [3:0] ii);
        for (int i = 0; i < n; i++) cycle(1'b0, 3'd0, 4'd0, 1'b0, 4'd0, ii);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_flush0"}, {31'd0, fl0}, 32'd0);
        chk({tag, "_busy0"}, {31'd0, bz0}, 32'd0);
        chk({tag, "_redirect0"}, {31'd0, rd0}, 32'd0);
        chk({tag, "_cnt0"}, {16'd0, cnt0}, 32'd0);
        chk({tag, "_flush1"}, {31'd0, fl1}, 32'd0);
        chk({tag, "_busy1"}, {31'd0, bz1}, 32'd0);
        chk({tag, "_cnt1"}, {30'd0, cnt1}, 32'd0);
    endtask

    initial begin
        model_reset();
        #1;
        check_reset_outputs("por");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset state and initial lookup
        idle(1, 4'd3);

        // JZ taken, predicted not-taken; a JN mispredict during FLUSH is ignored
        cycle(1'b1, 3'd1, 4'd5, 1'b0, 4'b0001, 4'd5);
        chk("jz_cnt", {16'd0, cnt0}, 32'd1);
        cycle(1'b1, 3'd2, 4'd7, 1'b1, 4'b0000, 4'd7);
        cycle(1'b1, 3'd2, 4'd7, 1'b1, 4'b0000, 4'd7);
        idle(2, 4'd5);

        // JN not-taken, predicted taken, then repeated while flushing
        cycle(1'b1, 3'd2, 4'd6, 1'b1, 4'b0000, 4'd6);
        cycle(1'b1, 3'd2, 4'd6, 1'b1, 4'b0000, 4'd6);
        idle(2, 4'd6);

        // Unconditional: correct prediction, then mispredict; no table update
        cycle(1'b1, 3'd4, 4'd8, 1'b1, 4'b0000, 4'd8);
        cycle(1'b1, 3'd4, 4'd8, 1'b0, 4'b0000, 4'd8);
        idle(3, 4'd8);

        // Four taken JC updates on idx 2, lookup on the same index each cycle
        for (int i = 0; i < 4; i++) cycle(1'b1, 3'd3, 4'd2, 1'b1, 4'b0100, 4'd2);
        idle(1, 4'd2);

        // JZ not-taken on idx 5 drops 2'b10 to 2'b01
        cycle(1'b1, 3'd1, 4'd5, 1'b1, 4'b1110, 4'd5);
        idle(3, 4'd5);

        // Types 0 and 5-7 never resolve
        cycle(1'b1, 3'd0, 4'd9, 1'b1, 4'b1111, 4'd9);
        cycle(1'b1, 3'd5, 4'd9, 1'b1, 4'b1111, 4'd9);
        cycle(1'b1, 3'd6, 4'd9, 1'b1, 4'b1111, 4'd9);
        cycle(1'b1, 3'd7, 4'd9, 1'b1, 4'b1111, 4'd9);

        // Back-to-back mispredicts: single-cycle flush resolves the third one
        cycle(1'b1, 3'd3, 4'd4, 1'b0, 4'b0100, 4'd4);
        cycle(1'b1, 3'd3, 4'd4, 1'b1, 4'b0000, 4'd4);
        cycle(1'b1, 3'd1, 4'd4, 1'b0, 4'b0001, 4'd4);
        idle(3, 4'd4);

        // Reset during the second flush cycle
        cycle(1'b1, 3'd1, 4'd1, 1'b0, 4'b0001, 4'd1);
        idle(1, 4'd1);
        chk("pre_rst_flush", {31'd0, fl0}, 32'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_flush_rst");
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(1, 4'd5);
        for (int i = 0; i < 16; i++) idle(1, 4'(i));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
